// File: rtl/ahb_slave_decoder_pkg.sv
// Shared encodings for the AHB-Lite slave decoder and its internal default slave.
// Optional error log is enabled by defining AHB_SLAVE_DECODER_ERRLOG_EN.
package ahb_slave_decoder_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // A transfer carries data only for NONSEQ and SEQ; IDLE and BUSY get a zero-wait OKAY.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR response for unmapped active transfers.
// With AHB_SLAVE_DECODER_ERRLOG_EN it also keeps a sticky log of the first failing address.
module ahb_default_slave
  import ahb_slave_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hready_i,
  input  logic        unmapped_i,
`ifdef AHB_SLAVE_DECODER_ERRLOG_EN
  input  logic [31:0] haddr_i,
  input  logic        err_clr_i,
  output logic        err_valid_o,
  output logic [31:0] err_addr_o,
`endif
  output logic        hready_o,
  output logic        hresp_o
);

  ds_state_e state_q, state_d;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    case (state_q)
      DS_IDLE: begin
        if (hready_i && unmapped_i) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = HRESP_ERROR;
        state_d = (hready_i && unmapped_i) ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DS_IDLE;
    else     state_q <= state_d;
  end

`ifdef AHB_SLAVE_DECODER_ERRLOG_EN
  logic        err_set;
  logic        err_valid_q, err_valid_d;
  logic [31:0] err_addr_q, err_addr_d;

  assign err_set = (state_d == DS_ERR1) && (state_q != DS_ERR1);

  // Set beats clear; the address is only taken while the log is empty.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (err_set) begin
      err_valid_d = 1'b1;
      if (!err_valid_q) err_addr_d = haddr_i;
    end else if (err_clr_i) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
`endif

endmodule

// File: rtl/ahb_slave_decoder.sv
// Single-master AHB-Lite address decoder and response multiplexer with internal default slave.
// Define AHB_SLAVE_DECODER_ERRLOG_EN to add the ERR_CLR/ERR_VALID/ERR_ADDR error log.
module ahb_slave_decoder
  import ahb_slave_decoder_pkg::*;
#(
  parameter int                   SLAVES     = 4,
  parameter logic [SLAVES*32-1:0] SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                32'h1000_0000, 32'h0000_0000},
  parameter logic [SLAVES*32-1:0] SLAVE_MASK = {4{32'hF000_0000}}
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic [1:0]        M_HTRANS,
  input  logic [31:0]       M_HADDR,
  output logic              M_HREADY,
  output logic [31:0]       M_HRDATA,
  output logic              M_HRESP,
  output logic [SLAVES-1:0] S_HSEL,
  output logic [SLAVES-1:0] S_HREADY,
  input  logic [SLAVES-1:0] S_HREADYOUT,
  input  logic [31:0]       S_HRDATA [SLAVES],
`ifdef AHB_SLAVE_DECODER_ERRLOG_EN
  input  logic              ERR_CLR,
  output logic              ERR_VALID,
  output logic [31:0]       ERR_ADDR,
`endif
  input  logic [SLAVES-1:0] S_HRESP
);

  logic [SLAVES-1:0] hsel;
  logic              no_match;
  logic              unmapped;
  logic [SLAVES-1:0] dsel_q, dsel_d;
  logic              ddef_q, ddef_d;
  logic              ds_hready, ds_hresp;

  // Lowest matching index wins, keeping the select one-hot when regions overlap.
  always_comb begin
    hsel     = '0;
    no_match = 1'b1;
    for (int i = 0; i < SLAVES; i++) begin
      if (no_match &&
          ((M_HADDR & SLAVE_MASK[32*i +: 32]) == (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]))) begin
        hsel[i]  = 1'b1;
        no_match = 1'b0;
      end
    end
  end

  assign S_HSEL   = hsel;
  assign S_HREADY = {SLAVES{M_HREADY}};
  assign unmapped = no_match && is_active(M_HTRANS);

  // Data-phase owner advances only when the current data phase completes.
  always_comb begin
    dsel_d = dsel_q;
    ddef_d = ddef_q;
    if (M_HREADY) begin
      dsel_d = hsel;
      ddef_d = unmapped;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      dsel_q <= '0;
      ddef_q <= 1'b0;
    end else begin
      dsel_q <= dsel_d;
      ddef_q <= ddef_d;
    end
  end

  ahb_default_slave u_default_slave (
    .clk        (CLK),
    .rst        (RES),
    .hready_i   (M_HREADY),
    .unmapped_i (unmapped),
`ifdef AHB_SLAVE_DECODER_ERRLOG_EN
    .haddr_i    (M_HADDR),
    .err_clr_i  (ERR_CLR),
    .err_valid_o(ERR_VALID),
    .err_addr_o (ERR_ADDR),
`endif
    .hready_o   (ds_hready),
    .hresp_o    (ds_hresp)
  );

  // With no data phase pending the bus idles ready/OKAY.
  always_comb begin
    M_HREADY = 1'b1;
    M_HRESP  = HRESP_OKAY;
    M_HRDATA = '0;
    if (|dsel_q) begin
      for (int i = 0; i < SLAVES; i++) begin
        if (dsel_q[i]) begin
          M_HREADY = S_HREADYOUT[i];
          M_HRESP  = S_HRESP[i];
          M_HRDATA = S_HRDATA[i];
        end
      end
    end else if (ddef_q) begin
      M_HREADY = ds_hready;
      M_HRESP  = ds_hresp;
    end
  end

endmodule

// File: doc/ahb_slave_decoder.md
Name: ahb_slave_decoder

Overview:
- Single-master AHB-Lite address decoder and response multiplexer. It sits directly upstream of the AHB slave array.
- Decodes the address phase into per-slave HSEL and fans HREADY out to all slaves.
- Holds a data-phase slave select and muxes HREADYOUT/HRDATA/HRESP back to the master.
- Contains an internal default slave that returns the two-cycle AHB ERROR response for unmapped transfers.

Parameters:
- SLAVES, 4, number of slave ports (1..16).
- SLAVE_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed SLAVES*32 base addresses; slave i occupies bits [32*i+31:32*i].
- SLAVE_MASK, {4{32'hF000_0000}}, packed SLAVES*32 compare masks. Slave i matches when (HADDR & mask_i) == (base_i & mask_i).

Ports:
- CLK  input  1  system clock
- RES  input  1  reset, asynchronous, active-high
- M_HTRANS  input  2  master transfer type
- M_HADDR  input  32  master address
- M_HREADY  output  1  bus HREADY to master; also the value fanned out to the slaves
- M_HRDATA  output  32  muxed read data
- M_HRESP  output  1  muxed response
- S_HSEL  output  1 [0:SLAVES-1]  per-slave select (address phase)
- S_HREADY  output  1 [0:SLAVES-1]  broadcast of M_HREADY
- S_HREADYOUT  input  1 [0:SLAVES-1]  slave ready
- S_HRDATA  input  32 [0:SLAVES-1]  slave read data
- S_HRESP  input  1 [0:SLAVES-1]  slave response
- HWDATA, HWRITE, HSIZE, HBURST, HPROT and HMASTLOCK are wired straight from master to slaves outside this block.

Behaviour:
- Address decode (combinational):
  - match_i as defined under SLAVE_MASK.
  - If several slaves match, the lowest index wins: the result is one-hot.
  - S_HSEL[i] = winning match_i; asserted regardless of HTRANS. Slaves qualify it with HTRANS.
  - no_match = no slave matches.
- Data-phase select register:
  - dsel (one-hot, SLAVES bits) and ddef (default slave selected) load on CLK when M_HREADY=1.
  - dsel <= S_HSEL.
  - ddef <= no_match & M_HTRANS[1].
  - Holds while M_HREADY=0.
  - Reset: dsel=0, ddef=0.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 on M_HREADY & no_match & M_HTRANS[1] (NONSEQ/SEQ).
  - DS_ERR1 drives HREADY=0, HRESP=1; always -> DS_ERR2.
  - DS_ERR2 drives HREADY=1, HRESP=1.
  - DS_ERR2 -> DS_ERR1 if another unmapped NONSEQ/SEQ is sampled; otherwise -> DS_IDLE.
  - IDLE/BUSY to an unmapped address: zero-wait OKAY, no FSM change.
- Response mux:
  - If dsel has bit i set: M_HREADY = S_HREADYOUT[i], M_HRDATA = S_HRDATA[i], M_HRESP = S_HRESP[i].
  - Else if ddef: from the FSM, with M_HRDATA = 0.
  - Else (no data phase pending): M_HREADY = 1, M_HRESP = 0, M_HRDATA = 0.
- S_HREADY[i] = M_HREADY for all i.
- Latency: no added cycles on mapped transfers. Unmapped transfers take exactly 2 data-phase cycles.
- Outputs during reset: M_HREADY=1, M_HRESP=0, M_HRDATA=0; S_HSEL follows M_HADDR decode; FSM=DS_IDLE.
- Reset asserted mid-wait: all state clears asynchronously. The next address phase after release is accepted normally.
- Back-to-back transfers to different slaves: the address phase of slave B overlaps the wait states of slave A. B's HSEL is visible, but B captures only when M_HREADY=1.

Optional Feature:
- Macro AHB_SLAVE_DECODER_ERRLOG_EN adds the ports ERR_CLR (input, 1), ERR_VALID (output, 1) and ERR_ADDR (output, 32).
- Address capture: a register captures M_HADDR on the same edge the FSM enters DS_ERR1.
- ERR_VALID is sticky. It is set on that edge and cleared by ERR_CLR=1 for one cycle. If set and clear coincide, set wins.
- ERR_ADDR holds the first error address; it is not overwritten while ERR_VALID=1.
- Reset value: 0.
- Without the macro: the ports and registers are absent; decode and response behaviour is identical.

Decomposition:
- Shared package/defines file holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and HRESP encodings (OKAY/ERROR).
  - The default-slave FSM state encodings.
- One natural sub-module: ahb_default_slave (the FSM plus optional error log), instantiated once.

Test Plan:
- Mapped read 0x1000_0010: S_HSEL[1]=1 in the address phase. Slave 1 holds HREADYOUT=0 for 2 cycles, then returns 0xDEAD_BEEF. M_HREADY is low 2 cycles, then M_HRDATA=0xDEAD_BEEF, M_HRESP=0.
- Unmapped NONSEQ 0x8000_0000: data phase gives cycle1 HREADY=0/HRESP=1, cycle2 HREADY=1/HRESP=1. With ERRLOG, ERR_ADDR=0x8000_0000 and ERR_VALID=1.
- IDLE to 0x8000_0000: M_HREADY=1, M_HRESP=0, FSM stays DS_IDLE.
- Back-to-back: NONSEQ 0x0000_0000 (slave 0 with 3 waits), then NONSEQ 0x3000_0004. S_HSEL[3] is held through the waits, and slave 3's data phase starts exactly on the cycle after slave 0 completes.
- Overlap: SLAVE_MASK[1] set to 0, so slave 1 matches everything. Address 0x0000_0000 selects slave 0 only; address 0x2000_0000 selects slave 1 only.
- Assert RES during slave 2 wait states: M_HREADY=1 and dsel=0 immediately. The first transfer after release completes normally.
